// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and write-port state encoding for the register-file write arbiter
package regfile_pkg;

  localparam int REG_IDX_W = 2;
  localparam int DATA_W    = 8;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } wr_state_t;

endpackage

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - two-requester register-file write port arbiter (WRARB_ROUND_ROBIN_EN selects round-robin ties)
module reg_write_arbiter
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_req,
  input  logic [REG_IDX_W-1:0] a_reg,
  input  logic [DATA_W-1:0]    a_data,
  output logic                 a_ack,
  input  logic                 b_req,
  input  logic [REG_IDX_W-1:0] b_reg,
  input  logic [DATA_W-1:0]    b_data,
  output logic                 b_ack,
  output logic [REG_IDX_W-1:0] WriteReg,
  output logic [DATA_W-1:0]    WriteData,
  output logic                 RegWrite,
  output logic [CNT_W-1:0]     wr_count
);

  wr_state_t state;
  wr_state_t nextState;
  logic      aElig;
  logic      bElig;

  // A requester whose ack is high this cycle is presenting a stale request.
  assign aElig = a_req && (state != GNT_A);
  assign bElig = b_req && (state != GNT_B);

`ifdef WRARB_ROUND_ROBIN_EN
  logic lastGrantB;

  function automatic wr_state_t arbitrate(input logic aOk, input logic bOk, input logic lastB);
    if (aOk && bOk) return lastB ? GNT_A : GNT_B;
    else if (aOk)   return GNT_A;
    else if (bOk)   return GNT_B;
    return IDLE;
  endfunction

  always_comb begin
    nextState = arbitrate(aElig, bElig, lastGrantB);
  end
`else
  function automatic wr_state_t arbitrate(input logic aOk, input logic bOk);
    if (aOk)      return GNT_A;
    else if (bOk) return GNT_B;
    return IDLE;
  endfunction

  always_comb begin
    nextState = arbitrate(aElig, bElig);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
      wr_count  <= '0;
`ifdef WRARB_ROUND_ROBIN_EN
      lastGrantB <= 1'b1;
`endif
    end else begin
      state    <= nextState;
      a_ack    <= (nextState == GNT_A);
      b_ack    <= (nextState == GNT_B);
      RegWrite <= (nextState != IDLE);
      // Count at the grant edge so wr_count already includes the write on the port.
      case (nextState)
        GNT_A: begin
          WriteReg  <= a_reg;
          WriteData <= a_data;
          wr_count  <= wr_count + 8'd1;
`ifdef WRARB_ROUND_ROBIN_EN
          lastGrantB <= 1'b0;
`endif
        end
        GNT_B: begin
          WriteReg  <= b_reg;
          WriteData <= b_data;
          wr_count  <= wr_count + 8'd1;
`ifdef WRARB_ROUND_ROBIN_EN
          lastGrantB <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
